// File: rtl/avalon_st_ta_fifo_gen_if.sv
// Avalon-ST stream bundle for avalon_st_ta_fifo_gen.
// The master drives the beat (valid and payload). The slave drives ready.
// The channel and empty fields are at least one bit wide, even when their
// configured width is zero.
interface avalon_st_ta_fifo_gen_if #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 0
);
  localparam int CH_PW = (CHANNEL_W > 0) ? CHANNEL_W : 1;
  localparam int EM_PW = (EMPTY_W > 0) ? EMPTY_W : 1;

  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [CH_PW-1:0]  channel;
  logic              startofpacket;
  logic              endofpacket;
  logic [EM_PW-1:0]  empty;

  modport master (
    output valid, data, channel, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, data, channel, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/avalon_st_ta_fifo_gen.sv
// avalon_st_ta_fifo_gen: Avalon-ST timing adapter. It converts a source
// ready latency of 0..3 to a ready latency of 0 on the sink side, using a
// show-ahead register FIFO. Payload {data, channel, sop, eop, empty} passes
// through unchanged. Zero-width fields are left out of the stored word.
// Optional macro AVST_TA_FIFO_OVERFLOW_CHECK_EN adds a sticky overflow port.
module avalon_st_ta_fifo_gen #(
  parameter int DATA_W           = 64,
  parameter int EMPTY_W          = 3,
  parameter int CHANNEL_W        = 0,
  parameter int DEPTH            = 8,
  parameter int IN_READY_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avalon_st_ta_fifo_gen_if.slave  in_if,
  avalon_st_ta_fifo_gen_if.master out_if,
  output logic [$clog2(DEPTH):0]  fill_level
`ifdef AVST_TA_FIFO_OVERFLOW_CHECK_EN
  ,
  output logic                    overflow
`endif
);
  localparam int L  = IN_READY_LATENCY;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int PW = DATA_W + CHANNEL_W + 2 + EMPTY_W;
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  // Leave room for the beats a latency-L source may still send after ready drops.
  localparam logic [FW-1:0] RDY_LIM  = FW'(DEPTH - L);

  if (DEPTH <= L + 1) begin : g_bad_cfg
    $error("avalon_st_ta_fifo_gen: DEPTH must exceed IN_READY_LATENCY+1");
  end

  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [PW-1:0] pack_in, pack_out;
  logic          in_rdy, wr_req, wr_en, rd_en, full, ovf;

  // Handshake decode, pointer advance and occupancy update
  always_comb begin
    in_rdy   = (fill_q < RDY_LIM);
    full     = (fill_q == DEPTH_F);
    rd_en    = (fill_q != '0) && out_if.ready;
    wr_req   = (L == 0) ? (in_if.valid && in_rdy) : in_if.valid;
    wr_en    = wr_req && (!full || rd_en);
    ovf      = wr_req && full && !rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    if (wr_en && !rd_en) begin
      fill_d = fill_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      fill_d = fill_q - 1'b1;
    end
  end

  // Control state: pointers and fill count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Payload storage has no reset; contents are only observed while fill is non-zero
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= pack_in;
    end
  end

  assign pack_out     = mem_q[rd_ptr_q];
  assign in_if.ready  = in_rdy;
  assign out_if.valid = (fill_q != '0);
  assign fill_level   = fill_q;

  if (CHANNEL_W > 0 && EMPTY_W > 0) begin : g_pack_ce
    assign pack_in = {in_if.data, in_if.channel, in_if.startofpacket,
                      in_if.endofpacket, in_if.empty};
    assign {out_if.data, out_if.channel, out_if.startofpacket,
            out_if.endofpacket, out_if.empty} = pack_out;
  end else if (CHANNEL_W > 0) begin : g_pack_c
    logic unused_empty;
    assign unused_empty = ^in_if.empty;
    assign pack_in = {in_if.data, in_if.channel, in_if.startofpacket, in_if.endofpacket};
    assign {out_if.data, out_if.channel, out_if.startofpacket, out_if.endofpacket} = pack_out;
    assign out_if.empty = '0;
  end else if (EMPTY_W > 0) begin : g_pack_e
    logic unused_channel;
    assign unused_channel = ^in_if.channel;
    assign pack_in = {in_if.data, in_if.startofpacket, in_if.endofpacket, in_if.empty};
    assign {out_if.data, out_if.startofpacket, out_if.endofpacket, out_if.empty} = pack_out;
    assign out_if.channel = '0;
  end else begin : g_pack_none
    logic unused_fields;
    assign unused_fields = ^{in_if.channel, in_if.empty};
    assign pack_in = {in_if.data, in_if.startofpacket, in_if.endofpacket};
    assign {out_if.data, out_if.startofpacket, out_if.endofpacket} = pack_out;
    assign out_if.channel = '0;
    assign out_if.empty   = '0;
  end

`ifdef AVST_TA_FIFO_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  // Sticky overflow flag, cleared only by reset
  always_comb begin
    overflow_d = overflow_q | ovf;
  end

  // Register the flag so it rises the cycle after the dropped write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifndef SYNTHESIS
  // Report each dropped beat in simulation
  always_ff @(posedge clk) begin
    if (reset_n && ovf) begin
      $error("avalon_st_ta_fifo_gen: write into full FIFO dropped");
    end
  end
`endif
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif
endmodule
